// File: rtl/cpa_pipe.sv
// Pipelined segmented carry-propagate adder: resolves redundant sum/carry vectors into
// a binary product, SEG bits per stage. Optional overflow flag output under CPA_OVF_EN.
module cpa_pipe #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] s_vec,
    input  logic [WIDTH-1:0] c_vec,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] prod,
    output logic             cout
`ifdef CPA_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int STAGES = WIDTH / SEG;

    generate
        if (SEG < 1 || (WIDTH % SEG) != 0) begin : g_bad_params
            $error("cpa_pipe: WIDTH must be a positive multiple of SEG");
        end
    endgenerate

    // SEG-bit ripple of full adders; returns {carry_out, sum}.
    function automatic logic [SEG:0] seg_add(input logic [SEG-1:0] a,
                                             input logic [SEG-1:0] b,
                                             input logic           ci);
        logic [SEG:0] r;
        logic         c;
        // NOTE: blocking assignments here model the ripple as an ordered chain of gates.
        c = ci;
        for (int i = 0; i < SEG; i++) begin
            r[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        r[SEG] = c;
        return r;
    endfunction

    logic             r_valid [STAGES];
    logic             r_carry [STAGES];
    logic [WIDTH-1:0] r_res   [STAGES];
    logic [WIDTH-1:0] r_s     [STAGES];
    logic [WIDTH-1:0] r_c     [STAGES];

    logic             w_src_valid [STAGES];
    logic             w_src_ci    [STAGES];
    logic [WIDTH-1:0] w_src_res   [STAGES];
    logic [WIDTH-1:0] w_src_s     [STAGES];
    logic [WIDTH-1:0] w_src_c     [STAGES];
    logic [SEG:0]     w_seg       [STAGES];
    logic [WIDTH-1:0] w_res_nxt   [STAGES];
    logic             w_stall;
    logic             w_unused;

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_src
            if (k == 0) begin : g_first
                assign w_src_valid[k] = in_valid;
                assign w_src_ci[k]    = cin;
                assign w_src_res[k]   = '0;
                assign w_src_s[k]     = s_vec;
                assign w_src_c[k]     = c_vec;
            end else begin : g_next
                assign w_src_valid[k] = r_valid[k-1];
                assign w_src_ci[k]    = r_carry[k-1];
                assign w_src_res[k]   = r_res[k-1];
                assign w_src_s[k]     = r_s[k-1];
                assign w_src_c[k]     = r_c[k-1];
            end
        end
    endgenerate

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            w_seg[k]     = seg_add(w_src_s[k][k*SEG +: SEG], w_src_c[k][k*SEG +: SEG], w_src_ci[k]);
            w_res_nxt[k] = w_src_res[k];
            w_res_nxt[k][k*SEG +: SEG] = w_seg[k][SEG-1:0];
        end
    end

    assign w_stall  = out_valid & ~out_ready;
    assign in_ready = ~w_stall;

    // Whole pipeline freezes on stall, so the presented result holds without a skid buffer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: data registers are reset too, so prod/cout read 0 after reset and
            // bubbles never carry X to the outputs.
            for (int k = 0; k < STAGES; k++) begin
                r_valid[k] <= 1'b0;
                r_carry[k] <= 1'b0;
                r_res[k]   <= '0;
                r_s[k]     <= '0;
                r_c[k]     <= '0;
            end
        end else if (!w_stall) begin
            for (int k = 0; k < STAGES; k++) begin
                r_valid[k] <= w_src_valid[k];
                r_carry[k] <= w_seg[k][SEG];
                r_res[k]   <= w_res_nxt[k];
                r_s[k]     <= w_src_s[k];
                r_c[k]     <= w_src_c[k];
            end
        end
    end

    assign out_valid = r_valid[STAGES-1];
    assign prod      = r_res[STAGES-1];
    assign cout      = r_carry[STAGES-1];

    // Operand copies in the last stage are never consumed.
    assign w_unused  = ^{r_s[STAGES-1], r_c[STAGES-1]};

`ifdef CPA_OVF_EN
    assign ovf = r_carry[STAGES-1] & r_valid[STAGES-1];
`endif

endmodule

// File: doc/cpa_pipe.md
# cpa_pipe

Pipelined final carry-propagate adder for the compressor-based multiplier. It sits directly downstream of the compressor tree and consumes the tree's redundant sum and carry vectors. It resolves them into the binary product using a segmented ripple of full adders, with the inter-segment carry registered between stages. A valid/ready handshake on both sides lets the multiplier datapath stall cleanly.

## Interface
Parameters:
- WIDTH, 16, width of the sum/carry vectors and of the product.
- SEG, 4, bits resolved per pipeline stage. WIDTH must be a multiple of SEG; any other value is an elaboration error. STAGES = WIDTH/SEG.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  sum/carry/cin valid this cycle.
- in_ready  output  1  stage accepts input this cycle.
- s_vec  input  WIDTH  sum vector from the compressor tree.
- c_vec  input  WIDTH  carry vector from the compressor tree, already aligned to weight.
- cin  input  1  carry into bit 0; normally 0.
- out_valid  output  1  prod/cout valid.
- out_ready  input  1  downstream accepts the result.
- prod  output  WIDTH  (s_vec + c_vec + cin) mod 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.
- ovf  output  1  present only with CPA_OVF_EN; see Configuration.

## Operation
- The pipeline has STAGES register stages. Each stage holds a valid bit, its running carry, the resolved low bits, and the unresolved high bits of s_vec and c_vec.
- Stage k adds bits [k*SEG +: SEG] of the two operands plus the incoming carry using a SEG-bit ripple of full adders.
  - It writes the SEG resolved bits into the result field.
  - It registers the segment carry-out for stage k+1.
  - Stage 0 takes its carry-in from cin.
- The last stage's registers drive prod, cout and out_valid directly. There is no combinational path from the operand inputs to any output.
- A transfer occurs on a rising edge where the respective valid and ready are both high.
- The stall condition is `stall = out_valid & ~out_ready`.
  - in_ready = ~stall, combinational, with no dependency on in_valid.
  - During a stall, every stage (valid bits included) holds its value.
  - When not stalled, all stages advance one step. Stage 0 loads in_valid and the operands.
- Bubbles are not collapsed: an invalid stage advances like a valid one.
- Results leave strictly in acceptance order.
- Data registers of invalid stages may update freely, but prod and cout must hold while out_valid=1 and out_ready=0.

## Timing
- Reset (rst_n=0 at a rising edge):
  - All valid bits go to 0; out_valid=0, prod=0, cout=0 (and ovf=0).
  - in_ready=1 from the first cycle after reset.
- Reset mid-operation flushes all in-flight transactions; none emerge afterwards.
- Latency: a transaction accepted at edge t gives out_valid=1 with its result after edge t+STAGES-1. For SEG=WIDTH this is one cycle after acceptance.
- Throughput is one result per cycle while out_ready=1.
- Simultaneous output handshake and input acceptance in the same cycle is legal and loses nothing.
- If out_ready falls while a result is presented, that result is held. in_ready drops in the same cycle.

## Configuration
- Macro: CPA_OVF_EN.
- Defined:
  - The ovf output port exists.
  - ovf = cout of the same result, registered alongside prod, and qualified so it reads 0 whenever out_valid=0.
  - Reset value is 0.
- Undefined: the ovf port is absent and the rest of the behaviour is unchanged.

## Test plan
All scenarios use WIDTH=16, SEG=4, so latency is 4 edges.
- Reset: hold rst_n=0 for 2 edges with in_valid=1 -> out_valid=0, prod=16'h0000, cout=0, in_ready=1; no output in the following 6 cycles.
- Single transaction: s_vec=16'h00FF, c_vec=16'h0001, cin=0 -> after 4 edges prod=16'h0100, cout=0, out_valid high for exactly 1 cycle.
- Full carry chain: s_vec=16'hFFFF, c_vec=16'h0000, cin=1 -> prod=16'h0000, cout=1 (ovf=1 if CPA_OVF_EN). Second operand pair s_vec=16'h8000, c_vec=16'h8000 -> prod=16'h0000, cout=1.
- Back-to-back streaming: 4 transactions (1+2, 16'h1234+16'h1111, 16'hFFF0+16'h0010, 16'h7FFF+16'h0001) with out_ready=1 -> results 16'h0003, 16'h2345, 16'h0000/cout=1, 16'h8000 on 4 consecutive cycles, in order.
- Backpressure: drop out_ready for 3 cycles while a result is presented -> prod/cout stable, in_ready=0. Raise out_ready -> the remaining queued results drain in order, with no duplicates and no loss.
- Reset mid-operation, then randomized: assert rst_n=0 with 3 transactions in flight -> out_valid stays 0 for the next 5 cycles. Then run 10k random s_vec/c_vec/cin values with random out_ready -> every result equals the scoreboard value s_vec+c_vec+cin.
